// File: rtl/morse_key_capture.sv
// Morse key capture: synchronizes, debounces and times a telegraph key, packing dots/dashes into a 10-bit code.
// Optional MORSE_WORD_GAP_EN adds a WORD state that emits a space code (10'b0) after a long silence.
module morse_key_capture #(
  parameter int TICK_DIV         = 500000,
  parameter int DEBOUNCE_TICKS   = 2,
  parameter int LONG_TICKS       = 20,
  parameter int LETTER_GAP_TICKS = 40,
  parameter int WORD_GAP_TICKS   = 100,
  parameter int CNT_W            = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [9:0] morse_out,
  output logic       morse_valid,
  output logic       overflow,
  output logic       busy
);

  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W   = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] LONG_TH   = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] LETTER_TH = CNT_W'(LETTER_GAP_TICKS);

  // Elaboration-time sanity check of the timing parameters.
  if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 || WORD_GAP_TICKS <= LETTER_GAP_TICKS ||
      WORD_GAP_TICKS >= (1 << CNT_W)) begin : g_bad_cfg
    $error("morse_key_capture: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESS   = 3'd1,
    S_GAP     = 3'd2,
    S_EMIT    = 3'd3,
    S_DISCARD = 3'd4
`ifdef MORSE_WORD_GAP_EN
    , S_WORD  = 3'd5
`endif
  } state_t;

  logic               key_meta_r, key_sync_r, key_deb_r;
  logic [PRESC_W-1:0] presc_r;
  logic [DEB_W-1:0]   deb_cnt_r;
  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   press_cnt_r, press_nxt_s, gap_cnt_r, gap_nxt_s;
  logic [CNT_W-1:0]   press_inc_s, gap_inc_s;
  logic [9:0]         buf_r, buf_nxt_s, morse_out_r, out_nxt_s;
  logic [2:0]         idx_r, idx_nxt_s;
  logic               valid_r, valid_nxt_s, ovf_r, ovf_nxt_s, busy_r;
  logic               tick_s, deb_done_s, change_s, rise_s, fall_s;
  logic [1:0]         sym_s;

  assign tick_s      = (presc_r == PRESC_W'(TICK_DIV - 1));
  assign deb_done_s  = ((deb_cnt_r + DEB_W'(1)) == DEB_W'(DEBOUNCE_TICKS));
  // The debounced edge is acted on in the same cycle the debounced level flips.
  assign change_s    = tick_s && (key_sync_r != key_deb_r) && deb_done_s;
  assign rise_s      = change_s && key_sync_r;
  assign fall_s      = change_s && !key_sync_r;
  assign press_inc_s = (press_cnt_r == CNT_MAX) ? press_cnt_r : press_cnt_r + CNT_W'(1);
  assign gap_inc_s   = (gap_cnt_r == CNT_MAX) ? gap_cnt_r : gap_cnt_r + CNT_W'(1);
  assign sym_s       = (press_cnt_r >= LONG_TH) ? 2'b11 : 2'b10;

  // Input synchronizer, tick prescaler and tick-based debounce.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta_r <= 1'b0;
      key_sync_r <= 1'b0;
      key_deb_r  <= 1'b0;
      presc_r    <= '0;
      deb_cnt_r  <= '0;
    end else begin
      key_meta_r <= key_in;
      key_sync_r <= key_meta_r;
      presc_r    <= tick_s ? '0 : presc_r + PRESC_W'(1);
      if (tick_s) begin
        if (key_sync_r != key_deb_r) begin
          if (deb_done_s) begin
            key_deb_r <= key_sync_r;
            deb_cnt_r <= '0;
          end else begin
            deb_cnt_r <= deb_cnt_r + DEB_W'(1);
          end
        end else begin
          deb_cnt_r <= '0;
        end
      end
    end
  end

  // Next-state and datapath decode; edges take priority over plain ticks.
  always_comb begin
    state_nxt_s = state_r;
    press_nxt_s = press_cnt_r;
    gap_nxt_s   = gap_cnt_r;
    buf_nxt_s   = buf_r;
    idx_nxt_s   = idx_r;
    out_nxt_s   = morse_out_r;
    valid_nxt_s = 1'b0;
    ovf_nxt_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (rise_s) begin
          state_nxt_s = S_PRESS;
          press_nxt_s = '0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_PRESS: begin
        if (fall_s) begin
          gap_nxt_s = '0;
          if (idx_r == 3'd5) begin
            ovf_nxt_s   = 1'b1;
            buf_nxt_s   = '0;
            idx_nxt_s   = '0;
            state_nxt_s = S_DISCARD;
          end else begin
            buf_nxt_s   = buf_r | ({sym_s, 8'b0} >> {idx_r, 1'b0});
            idx_nxt_s   = idx_r + 3'd1;
            state_nxt_s = S_GAP;
          end
        end else if (tick_s) begin
          press_nxt_s = press_inc_s;
        end else begin
          press_nxt_s = press_cnt_r;
        end
      end
      S_GAP: begin
        if (rise_s) begin
          state_nxt_s = S_PRESS;
          press_nxt_s = '0;
        end else if (tick_s) begin
          gap_nxt_s = gap_inc_s;
          if (gap_inc_s >= LETTER_TH) begin
            state_nxt_s = S_EMIT;
            out_nxt_s   = buf_r;
            valid_nxt_s = 1'b1;
            buf_nxt_s   = '0;
            idx_nxt_s   = '0;
          end else begin
            state_nxt_s = S_GAP;
          end
        end else begin
          gap_nxt_s = gap_cnt_r;
        end
      end
      S_EMIT: begin
`ifdef MORSE_WORD_GAP_EN
        state_nxt_s = S_WORD;
`else
        state_nxt_s = S_IDLE;
`endif
      end
      S_DISCARD: begin
        if (rise_s) begin
          gap_nxt_s = '0;
        end else if (tick_s && !key_deb_r) begin
          gap_nxt_s = gap_inc_s;
          if (gap_inc_s >= LETTER_TH) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_DISCARD;
          end
        end else begin
          gap_nxt_s = gap_cnt_r;
        end
      end
`ifdef MORSE_WORD_GAP_EN
      S_WORD: begin
        if (rise_s) begin
          state_nxt_s = S_PRESS;
          press_nxt_s = '0;
        end else if (tick_s) begin
          gap_nxt_s = gap_inc_s;
          if (gap_inc_s >= CNT_W'(WORD_GAP_TICKS)) begin
            state_nxt_s = S_IDLE;
            out_nxt_s   = 10'b0;
            valid_nxt_s = 1'b1;
          end else begin
            state_nxt_s = S_WORD;
          end
        end else begin
          gap_nxt_s = gap_cnt_r;
        end
      end
`endif
      default: begin
        state_nxt_s = S_IDLE;
        buf_nxt_s   = '0;
        idx_nxt_s   = '0;
      end
    endcase
  end

  // FSM state, counters, symbol buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      press_cnt_r <= '0;
      gap_cnt_r   <= '0;
      buf_r       <= '0;
      idx_r       <= '0;
      morse_out_r <= '0;
      valid_r     <= 1'b0;
      ovf_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      press_cnt_r <= press_nxt_s;
      gap_cnt_r   <= gap_nxt_s;
      buf_r       <= buf_nxt_s;
      idx_r       <= idx_nxt_s;
      morse_out_r <= out_nxt_s;
      valid_r     <= valid_nxt_s;
      ovf_r       <= ovf_nxt_s;
      busy_r      <= (state_nxt_s != S_IDLE);
    end
  end

  assign morse_out   = morse_out_r;
  assign morse_valid = valid_r;
  assign overflow    = ovf_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_morse_key_capture.sv
// Bench for morse_key_capture: directed letter scenarios plus random keying, checked every cycle
// against a letter-level model (symbol queue, press length and silence counts).
module tb_morse_key_capture;
  localparam int TDIV = 2, DEB = 1, LONG = 4, LGAP = 6, WGAP = 14, CW = 8;
  localparam int CMAX = (1 << CW) - 1;
`ifdef MORSE_WORD_GAP_EN
  localparam bit WORD_EN = 1'b1;
`else
  localparam bit WORD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_in = 1'b0;
  logic [9:0] morse_out;
  logic morse_valid, overflow, busy;

  always #5 clk = ~clk;

  morse_key_capture #(
    .TICK_DIV(TDIV), .DEBOUNCE_TICKS(DEB), .LONG_TICKS(LONG),
    .LETTER_GAP_TICKS(LGAP), .WORD_GAP_TICKS(WGAP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .morse_out(morse_out),
    .morse_valid(morse_valid), .overflow(overflow), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // model state
  int m_pcnt, m_run, m_press_len, m_silence;
  bit m_s1, m_s2, m_deb, m_pressing, m_discard, m_emit_pend, m_word_armed;
  bit sym_q[$];
  logic [9:0] e_out;
  bit e_valid, e_ovf, e_busy;

  // observations for literal checks
  int obs_valid, obs_ovf;
  logic [9:0] obs_out;
  bit obs_busy;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] pack_letter();
    logic [9:0] c;
    c = 10'b0;
    for (int i = 0; i < sym_q.size(); i++) c[9 - 2*i -: 2] = sym_q[i] ? 2'b11 : 2'b10;
    return c;
  endfunction

  task automatic model_step(bit k, bit r);
    bit tick, sync, rise, fall;
    if (r) begin
      m_pcnt = 0; m_run = 0; m_press_len = 0; m_silence = 0;
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_pressing = 0; m_discard = 0;
      m_emit_pend = 0; m_word_armed = 0; sym_q.delete();
      e_out = 10'b0; e_valid = 0; e_ovf = 0; e_busy = 0;
      return;
    end
    tick = (m_pcnt == TDIV - 1);
    m_pcnt = tick ? 0 : m_pcnt + 1;
    sync = m_s2; m_s2 = m_s1; m_s1 = k;
    rise = 0; fall = 0;
    if (tick) begin
      if (sync != m_deb) begin
        m_run++;
        if (m_run >= DEB) begin m_deb = sync; m_run = 0; rise = sync; fall = !sync; end
      end else m_run = 0;
    end
    e_valid = 0; e_ovf = 0;
    if (m_emit_pend) begin m_emit_pend = 0; m_word_armed = WORD_EN; end
    if (rise) begin
      if (m_discard) m_silence = 0;
      else begin m_pressing = 1; m_press_len = 0; m_word_armed = 0; end
    end else if (fall) begin
      if (!m_discard && m_pressing) begin
        m_pressing = 0; m_silence = 0;
        if (sym_q.size() == 5) begin e_ovf = 1; sym_q.delete(); m_discard = 1; end
        else sym_q.push_back(m_press_len >= LONG);
      end
    end else if (tick) begin
      if (m_pressing) m_press_len = (m_press_len < CMAX) ? m_press_len + 1 : CMAX;
      else if (m_discard) begin
        if (!m_deb) begin m_silence++; if (m_silence >= LGAP) m_discard = 0; end
      end else if (sym_q.size() > 0) begin
        m_silence++;
        if (m_silence >= LGAP) begin
          e_valid = 1; e_out = pack_letter(); sym_q.delete(); m_emit_pend = 1;
        end
      end else if (m_word_armed) begin
        m_silence = (m_silence < CMAX) ? m_silence + 1 : CMAX;
        if (m_silence >= WGAP) begin e_valid = 1; e_out = 10'b0; m_word_armed = 0; end
      end
    end
    e_busy = m_pressing || m_discard || (sym_q.size() > 0) || m_emit_pend || m_word_armed;
  endtask

  // one clock: drive at negedge, model the coming posedge, compare at next negedge
  task automatic step(bit k, bit r);
    key_in = k; rst = r;
    model_step(k, r);
    @(negedge clk);
    check("morse_out", morse_out, e_out);
    check("morse_valid", morse_valid, e_valid);
    check("overflow", overflow, e_ovf);
    check("busy", busy, e_busy);
    if (morse_valid) begin obs_valid++; obs_out = morse_out; end
    if (overflow) obs_ovf++;
    if (busy) obs_busy = 1;
  endtask

  task automatic hold(bit k, int ticks);
    repeat (ticks * TDIV) step(k, 1'b0);
  endtask

  task automatic clear_obs();
    obs_valid = 0; obs_ovf = 0; obs_busy = 0; obs_out = 10'b0;
  endtask

  initial begin
    @(negedge clk);
    step(1'b0, 1'b1);
    check("reset_out", morse_out, 10'b0);
    check("reset_valid", morse_valid, 1'b0);
    check("reset_ovf", overflow, 1'b0);
    check("reset_busy", busy, 1'b0);

    // letter A: dot dash
    clear_obs();
    hold(1, 2); hold(0, 2); hold(1, 6); hold(0, 10);
    check("A_count", obs_valid, 1);
    check("A_code", obs_out, 10'b10_11_00_00_00);
    check("A_ovf", obs_ovf, 0);

    // digit 0: five dashes
    clear_obs();
    repeat (5) begin hold(1, 6); hold(0, 2); end
    hold(0, 10);
    check("zero_count", obs_valid, 1);
    check("zero_code", obs_out, 10'b11_11_11_11_11);

    // six dots overflow the buffer
    clear_obs();
    repeat (6) begin hold(1, 2); hold(0, 2); end
    hold(0, 8);
    check("ovf_count", obs_ovf, 1);
    check("ovf_valid", obs_valid, 0);
    check("ovf_out_kept", morse_out, 10'b11_11_11_11_11);
    check("ovf_busy_drop", busy, 1'b0);

    // one-cycle glitch landing between ticks
    hold(0, 2);
    while (((m_pcnt + 2) % TDIV) == TDIV - 1) step(1'b0, 1'b0);
    clear_obs();
    step(1'b1, 1'b0);
    hold(0, 4);
    check("glitch_busy", obs_busy, 1'b0);
    check("glitch_valid", obs_valid, 0);
    check("glitch_ovf", obs_ovf, 0);

    // reset in the middle of a press
    clear_obs();
    hold(1, 3);
    step(1'b0, 1'b1);
    check("midrst_out", morse_out, 10'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", morse_valid, 1'b0);
    hold(0, 10);
    check("midrst_no_valid", obs_valid, 0);
    clear_obs();
    hold(1, 2); hold(0, 10);
    check("E_count", obs_valid, 1);
    check("E_code", obs_out, 10'b10_00_00_00_00);

    // E followed by a long silence: space only with the word-gap feature
    clear_obs();
    hold(1, 2); hold(0, 20);
    check("word_count", obs_valid, WORD_EN ? 2 : 1);
    check("word_last", obs_out, WORD_EN ? 10'b0 : 10'b10_00_00_00_00);

    // random keying with occasional glitches and resets
    for (int seg = 0; seg < 300; seg++) begin
      int r;
      r = $urandom_range(0, 24);
      if (r == 0) step($urandom_range(0, 1), 1'b1);
      else if (r == 1) begin
        repeat ($urandom_range(1, 2)) step(1'b1, 1'b0);
        repeat ($urandom_range(1, 5)) step(1'b0, 1'b0);
      end else begin
        repeat ($urandom_range(1, 16)) step(1'b1, 1'b0);
        repeat ($urandom_range(1, (r < 6) ? 40 : 14)) step(1'b0, 1'b0);
      end
    end
    hold(0, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/morse_key_capture.md
Name: morse_key_capture

Overview:
Upstream capture stage of the Morse decoder path. Samples the raw telegraph key, debounces it, and times each press and gap. It packs the symbols into a 10-bit code: 2 bits per symbol, first symbol in bits[9:8], `10` for dot, `11` for dash, `00` for empty. At each letter gap it emits the code with a one-cycle valid pulse for the downstream Morse-to-ASCII stage.

Parameters:
- TICK_DIV, 500000, clk cycles per timing tick (10 ms at 50 MHz); minimum 2.
- DEBOUNCE_TICKS, 2, consecutive ticks key must be stable before a level change is accepted.
- LONG_TICKS, 20, press length in ticks at or above which the symbol is a dash.
- LETTER_GAP_TICKS, 40, silent ticks after last release that close a letter.
- WORD_GAP_TICKS, 100, silent ticks after last release that close a word (optional feature only); must exceed LETTER_GAP_TICKS.
- CNT_W, 8, width of press/gap counters; all tick thresholds must be < 2^CNT_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_in  in  1  raw key, active-high (pressed = 1), asynchronous to clk
- morse_out  out  10  captured code, held stable between emissions
- morse_valid  out  1  one-cycle pulse: morse_out is new this cycle
- overflow  out  1  one-cycle pulse: sixth symbol received, letter discarded
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Reset values:
  - morse_out = 0, morse_valid = 0, overflow = 0, busy = 0.
  - Prescaler, counters, symbol index and shift buffer = 0.
  - Debounced key = 0; FSM = IDLE.
- Input conditioning:
  - key_in passes through a 2-flop synchronizer.
  - Prescaler issues a tick pulse every TICK_DIV clks.
  - Debounced key changes only on a tick, once the synchronized level has differed from it for DEBOUNCE_TICKS consecutive ticks.
- Counters:
  - Press and gap counters advance on ticks only and saturate at 2^CNT_W-1 (no wrap).
- FSM states:
  - IDLE: buffer empty. Debounced rise -> PRESS; press counter cleared.
  - PRESS: count ticks while key held. On debounced fall:
    - Classify the symbol: count >= LONG_TICKS -> `11`, else `10`.
    - Write the symbol into the buffer slot at the current index (index 0 = bits[9:8]) and increment the index.
    - Clear the gap counter and go to GAP.
  - GAP: count ticks while key released.
    - Rise before the gap counter reaches LETTER_GAP_TICKS -> PRESS; next symbol, same letter.
    - Counter reaches LETTER_GAP_TICKS -> EMIT.
  - EMIT, one cycle:
    - morse_out <= buffer; morse_valid = 1 for exactly this cycle.
    - Clear buffer and index.
    - Next state is IDLE, or WORD (optional feature only).
  - DISCARD: wait until LETTER_GAP_TICKS silent ticks have elapsed, then go to IDLE. No valid pulse. A rise during DISCARD restarts the gap count and the remaining presses are ignored.
- Latency: morse_valid asserts on the clk cycle after the tick on which the gap counter reaches LETTER_GAP_TICKS.
- Unused trailing slots in the emitted code stay `00`.
- Overflow:
  - A release that would write a sixth symbol sets overflow for 1 cycle, clears buffer and index, and goes to DISCARD.
  - morse_out keeps its previous value.
- Simultaneous tick and debounced edge: the edge wins. The counter is cleared, not incremented.
- Reset mid-press or mid-gap: all state is abandoned and no pulse is emitted. A key still held after reset is seen as a new press once debounce completes.

Optional Feature:
- Macro MORSE_WORD_GAP_EN.
- Defined:
  - EMIT goes to WORD; the gap counter keeps counting from its current value.
  - Counter reaches WORD_GAP_TICKS with key released -> emit morse_out = 10'b0 (space) with a one-cycle morse_valid, then go to IDLE.
  - A rise during WORD -> PRESS with no space emitted.
- Not defined: the WORD state does not exist, EMIT goes directly to IDLE, and a space code is never produced.

Test Plan:
All scenarios use TICK_DIV=2, DEBOUNCE_TICKS=1, LONG_TICKS=4, LETTER_GAP_TICKS=6, WORD_GAP_TICKS=14.
- "A": press 2 ticks, release 2, press 6, release 10 -> exactly one morse_valid with morse_out=10'b10_11_00_00_00; overflow stays 0.
- "0": five presses of 6 ticks separated by 2-tick gaps, then 10 silent -> one morse_valid, morse_out=10'b11_11_11_11_11.
- Overflow: six 2-tick presses with 2-tick gaps -> overflow pulses once on the sixth release; no morse_valid; morse_out keeps its prior value; busy drops after 6 silent ticks.
- Glitch: key_in high for 1 clk cycle between ticks -> no state change; busy stays 0; no pulses.
- Reset mid-press: assert rst for 1 cycle while key is held at tick 3 -> all outputs 0 the next cycle; no morse_valid after release; a later "E" (2-tick press) -> morse_out=10'b10_00_00_00_00.
- With MORSE_WORD_GAP_EN: "E" then 20 silent ticks -> a morse_valid with 10'b10_00_00_00_00, then a second morse_valid with 10'b0. Without the macro, only the first pulse occurs.
